// File: rtl/mul32_arbiter_if.sv
// Requester and multiplier signal bundle for mul32_arbiter.
// slave is the arbiter's view; master is the view of whatever drives the
// requesters and models the multiplier.
interface mul32_arbiter_if #(
  parameter int NREQ = 4
);
  // requester side
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_src1;
  logic [32*NREQ-1:0]   req_src2;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [63:0]          rsp_product;
  logic                 rsp_err;
  // shared multiplier side
  logic                 mul_start;
  logic [31:0]          mul_src1;
  logic [31:0]          mul_src2;
  logic [63:0]          mul_product;
  logic                 mul_done;

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready, mul_product, mul_done,
    output req_ready, rsp_valid, rsp_product, rsp_err,
           mul_start, mul_src1, mul_src2
  );

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready, mul_product, mul_done,
    input  req_ready, rsp_valid, rsp_product, rsp_err,
           mul_start, mul_src1, mul_src2
  );
endinterface

// File: rtl/mul32_arbiter.sv
// Round-robin front end sharing one sequential 32x32 multiplier among NREQ
// requesters. One op in flight at a time; a watchdog covers a multiplier that
// never pulses done, and a drain window after reset (and after a timeout)
// keeps us from starting a multiplier that is still busy.
module mul32_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63,
  parameter int DRAIN   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  mul32_arbiter_if.slave        bus,
  output logic                  err_sticky,
  output logic [15:0]           op_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW = $clog2(DRAIN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] LAST  = PW'(NREQ - 1);
  localparam logic [DW-1:0] D_END = DW'(DRAIN - 1);
  localparam logic [WW-1:0] W_END = WW'(TIMEOUT);

  localparam logic [2:0] S_DRAIN = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]             state;
  logic [DW-1:0]          drain_cnt;
  logic [WW-1:0]          wd_cnt;
  logic [PW-1:0]          ptr;      // last requester served
  logic [PW-1:0]          gnt;      // requester owning the in-flight op
  logic                   pend;     // timed-out response still owed to gnt

  logic [NREQ-1:0][31:0]  src1_a;
  logic [NREQ-1:0][31:0]  src2_a;

  logic [PW-1:0]          cand;
  logic [PW-1:0]          g;
  logic                   found;
  logic                   take;
  logic [NREQ-1:0]        gnt_oh;

  // unpack the flat operand buses into one word per requester
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign src1_a[i] = bus.req_src1[32*i +: 32];
    assign src2_a[i] = bus.req_src2[32*i +: 32];
  end

  // round-robin search: first valid requester after ptr, wrapping
  always_comb begin
    cand  = ptr;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == LAST) ? '0 : cand + 1'b1;
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        g     = cand;
      end
    end
  end

  assign bus.req_ready = (state == S_IDLE && found) ? (NREQ'(1) << g) : '0;
  assign take          = (state == S_IDLE) && found && bus.req_valid[g] && bus.req_ready[g];
  assign gnt_oh        = NREQ'(1) << gnt;

  // arbiter FSM, watchdog, response registers and status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_DRAIN;
      drain_cnt       <= '0;
      wd_cnt          <= '0;
      ptr             <= LAST;
      gnt             <= '0;
      pend            <= 1'b0;
      bus.mul_start   <= 1'b0;
      bus.mul_src1    <= '0;
      bus.mul_src2    <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_product <= '0;
      bus.rsp_err     <= 1'b0;
      err_sticky      <= 1'b0;
      op_count        <= '0;
    end else begin
      bus.mul_start <= 1'b0;
      case (state)
        // a done pulse here is the old op finishing, so the multiplier is free
        S_DRAIN: begin
          if (bus.mul_done || drain_cnt == D_END) begin
            drain_cnt <= '0;
            if (pend) begin
              pend          <= 1'b0;
              bus.rsp_valid <= gnt_oh;
              state         <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (take) begin
            gnt           <= g;
            bus.mul_src1  <= src1_a[g];
            bus.mul_src2  <= src2_a[g];
            bus.mul_start <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        // start pulse is on the bus this cycle; any done seen now is stale
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            bus.rsp_product <= bus.mul_product;
            bus.rsp_err     <= 1'b0;
            bus.rsp_valid   <= gnt_oh;
            state           <= S_RESP;
          end else if (wd_cnt == W_END) begin
            bus.rsp_product <= '0;
            bus.rsp_err     <= 1'b1;
            err_sticky      <= 1'b1;
            pend            <= 1'b1;
            drain_cnt       <= '0;
            state           <= S_DRAIN;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[gnt]) begin
            bus.rsp_valid <= '0;
            ptr           <= gnt;
            op_count      <= op_count + 16'd1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

endmodule
